instr_fetch_unit: RTL and testbench

//  Instruction fetch front end for the RISC-V core. Holds the fetch PC and issues

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues in-order word fetches, queues responses with
// their PC, and presents {pc, instr} to decode; a redirect flushes and drops stale data.
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   localparam int unsigned   PW   = $clog2(DEPTH);
   localparam int unsigned   CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {S_FETCH, S_FLUSH} state_t;

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic [XLEN-1:0] r_q_instr [DEPTH];
   logic [DEPTH-1:0] r_q_filled;
   logic [PW-1:0]   r_head, r_alloc, r_fill;
   logic [CW-1:0]   r_count;   // allocated entries
   logic [CW-1:0]   r_pend;    // allocated but not yet filled
   logic [CW-1:0]   r_drop;    // stale responses still to discard

   logic            w_req_hs, w_pop, w_drop, w_fill;
   logic [CW-1:0]   w_drop_redir;
   logic            w_unused_pc_lo;

   assign w_unused_pc_lo = ^redirect_pc[1:0];

   assign imem_req_valid = (r_state == S_FETCH) && (r_count < FULL) && !redirect_valid && !rst;
   assign imem_req_addr  = r_pc;

   assign if_valid = !rst && r_q_filled[r_head];
   assign if_pc    = if_valid ? r_q_pc[r_head]    : '0;
   assign if_instr = if_valid ? r_q_instr[r_head] : '0;

   assign w_req_hs = imem_req_valid && imem_req_ready;
   assign w_pop    = if_valid && if_ready;
   assign w_drop   = imem_rsp_valid && (r_drop != '0);
   assign w_fill   = imem_rsp_valid && (r_drop == '0) && (r_pend != '0);

   // On redirect every unfilled entry becomes a stale response to drop; a response
   // landing in the redirect cycle is discarded here rather than counted.
   assign w_drop_redir = r_drop - CW'(w_drop) + r_pend - CW'(w_fill);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid)
         w_state_nxt = (w_drop_redir != '0) ? S_FLUSH : S_FETCH;
      else if (r_state == S_FLUSH && r_drop == '0)
         w_state_nxt = S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_head     <= '0;
         r_alloc    <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_pend     <= '0;
         r_drop     <= '0;
         r_q_filled <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         r_head     <= '0;
         r_alloc    <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_pend     <= '0;
         r_drop     <= w_drop_redir;
         r_q_filled <= '0;
      end else begin
         if (w_req_hs) begin
            r_alloc <= r_alloc + PW'(1);
            r_pc    <= r_pc + XLEN'(4);
         end
         if (w_fill) begin
            r_q_filled[r_fill] <= 1'b1;
            r_fill             <= r_fill + PW'(1);
         end
         // The popped head is always filled, so it never collides with the fill slot
         if (w_pop) begin
            r_q_filled[r_head] <= 1'b0;
            r_head             <= r_head + PW'(1);
         end
         r_count <= r_count + CW'(w_req_hs) - CW'(w_pop);
         r_pend  <= r_pend + CW'(w_req_hs) - CW'(w_fill);
         r_drop  <= r_drop - CW'(w_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !redirect_valid) begin
         if (w_req_hs) r_q_pc[r_alloc]   <= r_pc;
         if (w_fill)   r_q_instr[r_fill] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with programmable latency,
// expected {pc, instr} pushed by stimulus and checked by an independent monitor.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_instr;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   typedef struct {logic [31:0] pc; logic [31:0] instr;} item_t;
   typedef struct {logic [31:0] addr; int due;} inf_t;

   item_t exp_q[$];
   inf_t  inflight[$];
   int    checks  = 0;
   int    errors  = 0;
   int    pop_cnt = 0;
   int    hs_cnt  = 0;
   int    ec      = 0;
   int    lat     = 1;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic push_exp(input logic [31:0] pc);
      item_t it;
      it.pc    = pc;
      it.instr = instr_of(pc);
      exp_q.push_back(it);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Memory: accepts on handshake, answers in order after lat cycles, one per cycle
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         ec++;
         if (rst) begin
            inflight.delete();
         end else begin
            if (imem_rsp_valid) void'(inflight.pop_front());
            if (imem_req_valid && imem_req_ready) begin
               inflight.push_back('{addr: imem_req_addr, due: ec + lat - 1});
               hs_cnt++;
            end
         end
         #1;
         if (inflight.size() > 0 && inflight[0].due <= ec) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(inflight[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Scoreboard monitor: every accepted output must be the next expected item
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready) begin
         pop_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got pc %h instr %h expected nothing", if_pc, if_instr);
         end else begin
            item_t e;
            e = exp_q.pop_front();
            if (if_pc !== e.pc || if_instr !== e.instr) begin
               errors++;
               $display("FAIL sb_item got pc %h instr %h expected pc %h instr %h",
                        if_pc, if_instr, e.pc, e.instr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Ends at the start of cycle 0 after reset with rst low
   task automatic do_reset;
      rst = 1'b1;
      tick();
      #1;
      chk1("rst_if_valid", if_valid, 1'b0);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_if_pc", if_pc, 32'h0);
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      chk_int(name, exp_q.size(), 0);
   endtask

   int pops0, hs0;

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; if_ready = 1'b0;

      // 1: streaming with 1-cycle memory
      lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
      pops0 = pop_cnt;
      #1;
      chk1("t1_req_valid_c0", imem_req_valid, 1'b1);
      chk("t1_req_addr_c0", imem_req_addr, 32'h0);
      tick(); #1;
      chk1("t1_if_valid_c1", if_valid, 1'b0);
      tick(); #1;
      chk1("t1_if_valid_c2", if_valid, 1'b1);
      chk("t1_if_pc_c2", if_pc, 32'h0);
      chk("t1_if_instr_c2", if_instr, instr_of(32'h0));
      repeat (6) tick();
      imem_req_ready = 1'b0;
      repeat (2) tick(); #1;
      chk_int("t1_gapless_pops", pop_cnt - pops0, 8);
      drain("t1_drain");

      // 2: decode stall fills the queue
      lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
      do_reset();
      hs0 = hs_cnt;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
      repeat (5) tick(); #1;
      chk1("t2_req_valid_full", imem_req_valid, 1'b0);
      chk_int("t2_reqs_when_full", hs_cnt - hs0, 4);
      repeat (4) tick(); #1;
      chk1("t2_if_valid_held", if_valid, 1'b1);
      chk("t2_if_pc_held", if_pc, 32'h0);
      tick();
      if_ready = 1'b1;
      #1;
      chk1("t2_req_valid_pop_cycle", imem_req_valid, 1'b0);
      tick(); #1;
      chk1("t2_req_valid_resume", imem_req_valid, 1'b1);
      chk("t2_req_addr_resume", imem_req_addr, 32'h10);
      tick();
      imem_req_ready = 1'b0;
      drain("t2_drain");
      chk_int("t2_total_reqs", hs_cnt - hs0, 5);

      // 3: memory back-pressure
      lat = 1; imem_req_ready = 1'b0; if_ready = 1'b1;
      do_reset();
      hs0 = hs_cnt;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk1("t3_req_valid_stall", imem_req_valid, 1'b1);
         chk("t3_req_addr_stable", imem_req_addr, 32'h0);
         tick();
      end
      imem_req_ready = 1'b1;
      #1;
      chk1("t3_no_alloc_if_valid", if_valid, 1'b0);
      chk_int("t3_no_handshake", hs_cnt - hs0, 0);
      repeat (3) tick();
      imem_req_ready = 1'b0;
      drain("t3_drain");

      // 4: redirect with two requests in flight, 3-cycle memory
      lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
      do_reset();
      push_exp(32'h100);
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      chk1("t4_req_valid_redirect", imem_req_valid, 1'b0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk1("t4_flush_c3", imem_req_valid, 1'b0);
      chk1("t4_if_valid_c3", if_valid, 1'b0);
      tick(); #1;
      chk1("t4_flush_c4", imem_req_valid, 1'b0);
      tick(); #1;
      chk1("t4_flush_c5", imem_req_valid, 1'b0);
      chk1("t4_if_valid_c5", if_valid, 1'b0);
      tick(); #1;
      chk1("t4_req_valid_c6", imem_req_valid, 1'b1);
      chk("t4_req_addr_c6", imem_req_addr, 32'h100);
      tick();
      imem_req_ready = 1'b0;
      drain("t4_drain");

      // 5a: misaligned redirect target with nothing in flight
      lat = 3; imem_req_ready = 1'b0; if_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      #1;
      chk1("t5_req_valid_redirect", imem_req_valid, 1'b0);
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      chk1("t5_req_valid_aligned", imem_req_valid, 1'b1);
      chk("t5_req_addr_aligned", imem_req_addr, 32'h200);
      push_exp(32'h200);
      tick();
      imem_req_ready = 1'b0;
      drain("t5a_drain");

      // 5b: second redirect while flushing
      imem_req_ready = 1'b1;
      #1;
      chk("t5_req_addr_next", imem_req_addr, 32'h204);
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
      #1;
      chk1("t5_req_valid_r1", imem_req_valid, 1'b0);
      tick();
      redirect_pc = 32'h300;
      #1;
      chk1("t5_req_valid_r2", imem_req_valid, 1'b0);
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      chk1("t5_flush_t3", imem_req_valid, 1'b0);
      chk("t5_pc_after_r2", imem_req_addr, 32'h300);
      tick(); #1;
      chk1("t5_flush_t4", imem_req_valid, 1'b0);
      tick(); #1;
      chk1("t5_req_valid_t5", imem_req_valid, 1'b1);
      chk("t5_req_addr_t5", imem_req_addr, 32'h300);
      push_exp(32'h300);
      tick();
      imem_req_ready = 1'b0;
      drain("t5b_drain");

      // 6: reset mid-stream with responses pending
      lat = 3; imem_req_ready = 1'b1; if_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      imem_req_ready = 1'b0;
      tick(); #1;
      chk1("t6_if_valid_pre", if_valid, 1'b1);
      chk("t6_if_pc_pre", if_pc, 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk1("t6_if_valid_in_rst", if_valid, 1'b0);
      chk1("t6_req_valid_in_rst", imem_req_valid, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk1("t6_if_valid_post", if_valid, 1'b0);
      chk("t6_req_addr_post", imem_req_addr, 32'h0);
      chk1("t6_req_valid_post", imem_req_valid, 1'b1);
      repeat (3) tick(); #1;
      chk1("t6_if_valid_later", if_valid, 1'b0);
      chk_int("t6_sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
